ccip_polling_receiver: RTL and testbench
========================================

// Module: ccip_polling_receiver
// PURPOSE
//  RX path of the CPU-NIC interface. Polls per-flow RX rings in host memory with CCI-P
//  eREQ_RDLINE_I reads on channel c0 and extracts host-posted RPCs. Delivers each RPC to the
//  NIC core with a valid/ready handshake. Counterpart of the batched-write TX path.
//  Flows are polled round-robin, with one outstanding read at a time.
// PARAMETERS
//  NIC_ID             0  NIC index, used only in $display tags
//  LMAX_NUM_OF_FLOWS  1  log2 of the max number of RX flows (MAX_FLOWS = 2**LMAX_NUM_OF_FLOWS)
//  LNUM_SLOTS         2  log2 of the cache-line slots per flow ring
// PORTS
//  clk              in   1                  clock
//  reset            in   1                  synchronous, active-high
//  number_of_flows  in   LMAX_NUM_OF_FLOWS  highest active flow index (0 = flow 0 only)
//  rx_base_addr     in   t_ccip_clAddr      CL address of flow 0 / slot 0
//  start            in   1                  enable polling
//  sRx_c0TxAlmFull  in   1                  c0 request channel almost full
//  sTx_c0           out  t_if_ccip_c0_Tx    read requests
//  sRx_c0           in   t_if_ccip_c0_Rx    read responses
//  rpc_out          out  $bits(RpcIf)       received RPC
//  rpc_out_valid    out  1                  rpc_out/rpc_flow_id_out valid
//  rpc_flow_id_out  out  LMAX_NUM_OF_FLOWS  flow of rpc_out
//  rpc_out_ready    in   1                  consumer accepts
//  error            out  1                  sticky protocol error
//  stat_polls       out  32                 reads issued (wraps)
//  stat_rpcs        out  32                 RPCs delivered (wraps)
// BEHAVIOUR
//  - Reset: all outputs are 0, sTx_c0.valid=0, state=S_IDLE, flow_cnt=0, head[*]=0, phase[*]=1.
//  - Slot address: rx_base_addr + (flow_cnt << LNUM_SLOTS) + head[flow_cnt]. Ring f covers
//    2**LNUM_SLOTS consecutive CLs.
//  - Line format: data[$bits(RpcIf)-1:0] = RPC, data[511] = host phase flag.
//    A slot is full when data[511] == phase[flow].
//  - FSM states: S_IDLE, S_REQ, S_WAIT, S_OUT.
//    - S_IDLE: if start, go to S_REQ; otherwise stay.
//    - S_REQ: if !start, go to S_IDLE. If start && !sRx_c0TxAlmFull, then in the next cycle
//      drive sTx_c0.valid=1 for exactly 1 cycle with:
//        hdr = 0, except req_type = eREQ_RDLINE_I, vc_sel = eVC_VH0, cl_len = eCL_LEN_1,
//        address = slot address, mdata[LMAX_NUM_OF_FLOWS-1:0] = flow_cnt;
//      stat_polls++ and go to S_WAIT. If almost full, hold in S_REQ with no request.
//    - S_WAIT: on sRx_c0.rspValid && resp_type == eRSP_RDLINE:
//        mdata flow != flow_cnt    -> error <= 1; treat as empty slot.
//        flag == phase[flow_cnt]   -> latch data into rpc_out, go to S_OUT.
//        otherwise (empty)         -> advance flow_cnt, go to S_REQ.
//      Responses with other resp_type, and MMIO traffic, are ignored.
//    - S_OUT: rpc_out_valid=1 the cycle after the response. rpc_out and rpc_flow_id_out are
//      stable while valid && !ready. On valid && ready:
//        head[flow]++; on wrap to 0, phase[flow] toggles; stat_rpcs++;
//        advance flow_cnt; rpc_out_valid drops the next cycle; go to S_REQ.
//  - Advance flow_cnt: if flow_cnt == number_of_flows, set it to 0, else increment.
//    A dynamic shrink of number_of_flows below flow_cnt also wraps to 0 on the next advance.
//  - start deasserted in S_WAIT or S_OUT: finish the read and the delivery first, then the FSM
//    reaches S_IDLE from S_REQ. Ring state (head, phase) is kept across start toggles.
//  - An eRSP_RDLINE response outside S_WAIT sets error and is dropped.
//  - Reset mid-operation: return to reset state immediately. Any response already in flight
//    after reset falls outside S_WAIT, so it is dropped; error stays 0 until 4 cycles after
//    reset release.
//  - Latency: read response to rpc_out_valid = 1 cycle. Accept to next read request = 2 cycles.
// TESTING
//  1. Reset, then start=1, 1 flow, slot0 flag=0.
//     -> reads at base+0 repeat; rpc_out_valid stays 0; stat_polls increments per read.
//  2. Host writes slot0 with RPC=0xA5, flag=1, ready=1.
//     -> rpc_out=0xA5, flow 0, 1 cycle after rsp; next read at base+1.
//  3. 4 slots filled with flag=1, then refill with flag=0.
//     -> 8 RPCs delivered; phase[0] toggles after the 4th RPC; head returns to 0.
//  4. number_of_flows=1, only flow 1 full.
//     -> reads alternate base+0 and base+4; rpc_flow_id_out=1.
//  5. ready=0 for 10 cycles.
//     -> rpc_out held stable; no new c0 request until the accept.
//     sRx_c0TxAlmFull=1 -> sTx_c0.valid stays 0 while it is high.
//  6. Response mdata=1 while flow_cnt=0, or an unsolicited response in S_IDLE.
//     -> error=1 and stays set until reset.

Source files
------------

// File: rtl/ccip_polling_receiver.sv
// RX-ring poller: reads per-flow host rings round-robin over CCI-P c0 (one read in flight)
// and hands host-posted RPCs to the NIC core through a valid/ready port.
module ccip_polling_receiver #(
  parameter int NIC_ID            = 0,
  parameter int LMAX_NUM_OF_FLOWS = 1,
  parameter int LNUM_SLOTS        = 2,
  parameter int RPC_WIDTH         = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LMAX_NUM_OF_FLOWS-1:0] number_of_flows,
  input  logic [41:0]                  rx_base_addr,
  input  logic                         start,
  input  logic                         sRx_c0TxAlmFull,
  output logic [74:0]                  sTx_c0,
  input  logic [542:0]                 sRx_c0,
  output logic [RPC_WIDTH-1:0]         rpc_out,
  output logic                         rpc_out_valid,
  output logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_out,
  input  logic                         rpc_out_ready,
  output logic                         error,
  output logic [31:0]                  stat_polls,
  output logic [31:0]                  stat_rpcs
);

  // sTx_c0 is the packed t_if_ccip_c0_Tx {hdr[73:0], valid}; sRx_c0 is the packed
  // t_if_ccip_c0_Rx {hdr[27:0], data[511:0], rspValid, mmioRdValid, mmioWrValid}.
  localparam int MAX_FLOWS = 2 ** LMAX_NUM_OF_FLOWS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam logic [3:0] REQ_RDLINE_I = 4'h0;
  localparam logic [3:0] RSP_RDLINE   = 4'h0;
  localparam logic [1:0] VC_VH0       = 2'h2;
  localparam logic [1:0] CL_LEN_1     = 2'h0;

  logic [1:0]                   state;
  logic [LMAX_NUM_OF_FLOWS-1:0] flow_cnt;
  logic [LNUM_SLOTS-1:0]        head [MAX_FLOWS];
  logic [MAX_FLOWS-1:0]         phase;
  logic [2:0]                   quiet_cnt;

  logic                         rdline_rsp;
  logic                         flow_match;
  logic                         slot_full;
  logic [LMAX_NUM_OF_FLOWS-1:0] next_flow;
  logic [41:0]                  slot_addr;
  logic                         unused_ok;

  assign rdline_rsp = sRx_c0[2] && (sRx_c0[534:531] == RSP_RDLINE);
  assign flow_match = (sRx_c0[515 +: LMAX_NUM_OF_FLOWS] == flow_cnt);
  assign slot_full  = flow_match && (sRx_c0[514] == phase[flow_cnt]);
  // >= rather than == so a shrink of number_of_flows below flow_cnt still wraps to flow 0
  assign next_flow  = (flow_cnt >= number_of_flows) ? '0 : flow_cnt + 1'b1;
  assign slot_addr  = rx_base_addr + (42'(flow_cnt) << LNUM_SLOTS) + 42'(head[flow_cnt]);
  assign unused_ok  = ^{sRx_c0, NIC_ID != 0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      flow_cnt        <= '0;
      phase           <= '1;
      quiet_cnt       <= 3'd4;
      sTx_c0          <= '0;
      rpc_out         <= '0;
      rpc_out_valid   <= 1'b0;
      rpc_flow_id_out <= '0;
      error           <= 1'b0;
      stat_polls      <= '0;
      stat_rpcs       <= '0;
      for (int i = 0; i < MAX_FLOWS; i++) head[i] <= '0;
    end else begin
      sTx_c0 <= '0;
      if (quiet_cnt != 3'd0) quiet_cnt <= quiet_cnt - 3'd1;
      case (state)
        S_IDLE: if (start) state <= S_REQ;
        S_REQ: begin
          if (!start) begin
            state <= S_IDLE;
          end else if (!sRx_c0TxAlmFull) begin
            sTx_c0     <= {VC_VH0, 2'b00, CL_LEN_1, REQ_RDLINE_I, 6'b0, slot_addr,
                           16'(flow_cnt), 1'b1};
            stat_polls <= stat_polls + 32'd1;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rdline_rsp) begin
            if (!flow_match) error <= 1'b1;
            if (slot_full) begin
              rpc_out         <= sRx_c0[3 +: RPC_WIDTH];
              rpc_flow_id_out <= flow_cnt;
              rpc_out_valid   <= 1'b1;
              state           <= S_OUT;
            end else begin
              flow_cnt <= next_flow;
              state    <= S_REQ;
            end
          end
        end
        default: begin
          if (rpc_out_ready) begin
            head[flow_cnt] <= head[flow_cnt] + 1'b1;
            if (&head[flow_cnt]) phase[flow_cnt] <= ~phase[flow_cnt];
            stat_rpcs     <= stat_rpcs + 32'd1;
            flow_cnt      <= next_flow;
            rpc_out_valid <= 1'b0;
            state         <= S_REQ;
          end
        end
      endcase
      // Stray read responses are protocol errors, except stale ones landing just after reset
      if (rdline_rsp && state != S_WAIT && quiet_cnt == 3'd0) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ccip_polling_receiver.sv
// Bench for ccip_polling_receiver: acts as host memory with per-flow producer rings and
// predicts reads, deliveries and statistics from a ring-level model.
module tb_ccip_polling_receiver;

  localparam int LF    = 1;
  localparam int LS    = 2;
  localparam int RW    = 64;
  localparam int FLOWS = 2 ** LF;
  localparam int SLOTS = 2 ** LS;
  localparam int LINES = FLOWS * SLOTS;

  localparam int RX_VALID = 2;
  localparam int RX_DATA  = 3;
  localparam int RX_MDATA = 515;

  logic          clk = 1'b0;
  logic          reset;
  logic [LF-1:0] nflows;
  logic [41:0]   base;
  logic          start;
  logic          alm;
  logic [74:0]   tx;
  logic [542:0]  rx;
  logic [RW-1:0] rpc;
  logic          rpc_valid;
  logic [LF-1:0] rpc_flow;
  logic          ready;
  logic          error;
  logic [31:0]   polls;
  logic [31:0]   rpcs;

  ccip_polling_receiver #(
    .NIC_ID(0), .LMAX_NUM_OF_FLOWS(LF), .LNUM_SLOTS(LS), .RPC_WIDTH(RW)
  ) dut (
    .clk(clk), .reset(reset), .number_of_flows(nflows), .rx_base_addr(base),
    .start(start), .sRx_c0TxAlmFull(alm), .sTx_c0(tx), .sRx_c0(rx),
    .rpc_out(rpc), .rpc_out_valid(rpc_valid), .rpc_flow_id_out(rpc_flow),
    .rpc_out_ready(ready), .error(error), .stat_polls(polls), .stat_rpcs(rpcs)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Host producer side and NIC consumer side of every ring, tracked as plain counters
  int            cons_head [FLOWS];
  bit            cons_phase[FLOWS];
  int            prod_ptr  [FLOWS];
  bit            prod_phase[FLOWS];
  int            pending   [FLOWS];
  logic [RW-1:0] mem_rpc   [LINES];
  bit            mem_flag  [LINES];
  int            exp_flow;
  int            exp_polls;
  int            exp_rpcs;
  bit            exp_err;

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [542:0] make_rsp(input int mdata, input bit flag, input logic [RW-1:0] val);
    logic [542:0] r;
    r = '0;
    r[RX_VALID]          = 1'b1;
    r[RX_MDATA +: 16]    = 16'(mdata);
    r[RX_DATA + 511]     = flag;
    r[RX_DATA +: RW]     = val;
    return r;
  endfunction

  task automatic apply_reset();
    reset = 1'b1; start = 1'b0; alm = 1'b0; ready = 1'b0; rx = '0;
    repeat (3) @(negedge clk);
    for (int f = 0; f < FLOWS; f++) begin
      cons_head[f] = 0; cons_phase[f] = 1'b1;
      prod_ptr[f]  = 0; prod_phase[f] = 1'b1; pending[f] = 0;
    end
    for (int l = 0; l < LINES; l++) begin
      mem_flag[l] = 1'b0; mem_rpc[l] = '0;
    end
    exp_flow = 0; exp_polls = 0; exp_rpcs = 0; exp_err = 1'b0;
    check_output("rst_tx", tx, 0);
    check_output("rst_valid", rpc_valid, 0);
    check_output("rst_rpc", rpc, 0);
    check_output("rst_flow", rpc_flow, 0);
    check_output("rst_error", error, 0);
    check_output("rst_polls", polls, 0);
    check_output("rst_rpcs", rpcs, 0);
    reset = 1'b0;
  endtask

  task automatic host_post(input int f, input logic [RW-1:0] val);
    int line;
    if (pending[f] < SLOTS) begin
      line           = f * SLOTS + prod_ptr[f];
      mem_rpc[line]  = val;
      mem_flag[line] = prod_phase[f];
      prod_ptr[f]++;
      if (prod_ptr[f] == SLOTS) begin
        prod_ptr[f]   = 0;
        prod_phase[f] = ~prod_phase[f];
      end
      pending[f]++;
    end
  endtask

  // One poll: wait for the read, answer it from host memory, then take any delivered RPC
  task automatic apply_stimulus(input int hold, input bit bad_mdata, input bit chk_lat,
                                input bit drop_start);
    int            waited;
    int            line;
    bit            full;
    logic [RW-1:0] exp_rpc;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!tx[0] && waited < 30);
    check_output("req_seen", tx[0], 1);
    if (!tx[0]) return;
    if (chk_lat) check_output("req_latency", waited, 1);
    if (drop_start) start = 1'b0;
    line = exp_flow * SLOTS + cons_head[exp_flow];
    exp_polls++;
    check_output("req_hdr", tx[74:1],
                 {2'h2, 2'b00, 2'b00, 4'h0, 6'b0, base + 42'(line), 16'(exp_flow)});
    check_output("stat_polls", polls, exp_polls);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      check_output("single_outstanding", tx[0], 0);
    end
    full = !bad_mdata && (mem_flag[line] == cons_phase[exp_flow]);
    rx = make_rsp(bad_mdata ? (exp_flow ^ 1) : exp_flow, mem_flag[line], mem_rpc[line]);
    @(negedge clk);
    rx = '0;
    if (bad_mdata) exp_err = 1'b1;
    check_output("rpc_valid", rpc_valid, full);
    if (full) begin
      exp_rpc = mem_rpc[line];
      check_output("rpc_data", rpc, exp_rpc);
      check_output("rpc_flow", rpc_flow, exp_flow);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check_output("hold_data", rpc, exp_rpc);
        check_output("hold_valid", rpc_valid, 1);
        check_output("hold_no_req", tx[0], 0);
      end
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      exp_rpcs++;
      pending[exp_flow]--;
      cons_head[exp_flow]++;
      if (cons_head[exp_flow] == SLOTS) begin
        cons_head[exp_flow]  = 0;
        cons_phase[exp_flow] = ~cons_phase[exp_flow];
      end
      check_output("valid_drop", rpc_valid, 0);
      check_output("stat_rpcs", rpcs, exp_rpcs);
    end
    exp_flow = (exp_flow >= int'(nflows)) ? 0 : exp_flow + 1;
    check_output("error", error, exp_err);
  endtask

  initial begin
    nflows = '0;
    base   = 42'({$urandom, $urandom});
    apply_reset();
    $display("[TB] stale response inside the post-reset window");
    rx = make_rsp(0, 1'b1, 64'h1);
    @(negedge clk);
    rx = '0;
    repeat (5) @(negedge clk);
    check_output("quiet_window_error", error, 0);

    $display("[TB] empty ring polling");
    start = 1'b1;
    apply_stimulus(0, 0, 0, 0);
    repeat (2) apply_stimulus(0, 0, 1, 0);

    $display("[TB] single RPC then ring wrap with phase flip");
    host_post(0, 64'hA5);
    apply_stimulus(0, 0, 1, 0);
    apply_stimulus(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) host_post(0, {$urandom, $urandom});
    repeat (4) apply_stimulus($urandom_range(0, 2), 0, 1, 0);
    apply_stimulus(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) host_post(0, {$urandom, $urandom});
    repeat (5) apply_stimulus($urandom_range(0, 2), 0, 1, 0);

    $display("[TB] two flows, only flow 1 posted");
    nflows = 1'b1;
    host_post(1, {$urandom, $urandom});
    host_post(1, {$urandom, $urandom});
    repeat (6) apply_stimulus(0, 0, 1, 0);

    $display("[TB] consumer back-pressure and almost-full");
    host_post(exp_flow, {$urandom, $urandom});
    apply_stimulus(10, 0, 1, 0);
    alm = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check_output("almfull_no_req", tx[0], 0);
    end
    alm = 1'b0;
    apply_stimulus(0, 0, 0, 0);

    $display("[TB] start dropped mid-delivery");
    host_post(exp_flow, {$urandom, $urandom});
    apply_stimulus(3, 0, 1, 1);
    repeat (4) begin
      @(negedge clk);
      check_output("stopped_no_req", tx[0], 0);
    end
    start = 1'b1;
    apply_stimulus(0, 0, 0, 0);

    $display("[TB] randomized traffic");
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) == 0) host_post($urandom_range(0, FLOWS - 1), {$urandom, $urandom});
      if ($urandom_range(0, 7) == 0) nflows = LF'($urandom_range(0, FLOWS - 1));
      apply_stimulus($urandom_range(0, 3), 0, 1, 0);
    end

    $display("[TB] protocol errors");
    apply_stimulus(0, 1, 1, 0);
    apply_stimulus(0, 0, 1, 0);
    apply_reset();
    rx = make_rsp(0, 1'b0, '0);
    @(negedge clk);
    rx = '0;
    repeat (6) @(negedge clk);
    check_output("idle_quiet_error", error, 0);
    rx = make_rsp(0, 1'b1, 64'h5);
    @(negedge clk);
    rx = '0;
    @(negedge clk);
    check_output("unsolicited_error", error, 1);
    repeat (3) @(negedge clk);
    check_output("error_sticky", error, 1);
    check_output("idle_no_rpc", rpc_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
